// File: rtl/alu_stage_mc.sv
// alu_stage_mc: execute stage with a pipeline register, operand-B select,
// a single-cycle ALU and an optional iterative unsigned multiplier.
// Define ALU_STAGE_MUL_EN to build the multiplier datapath and its FSM;
// without it, cop 1000 returns 0 in one cycle and busy is tied low.
module alu_stage_mc #(
  parameter int DATA_W  = 16,
  parameter int IMM_W   = 9,
  parameter int RADDR_W = 3,
  parameter int MUL_BPC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_alu,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  regA,
  input  logic [DATA_W-1:0]  regB,
  input  logic [3:0]         cop,
  input  logic [IMM_W-1:0]   inmediate,
  input  logic               word_access_from_decode,
  input  logic [DATA_W-1:0]  dataReg,
  input  logic [1:0]         ldSt_enable,
  input  logic [RADDR_W-1:0] destReg_addr,
  input  logic               we,
  input  logic [1:0]         bp_input,
  output logic [DATA_W-1:0]  alu_result,
  output logic               OVF,
  output logic               out_valid,
  output logic               busy,
  output logic               word_access,
  output logic [DATA_W-1:0]  dataReg_output,
  output logic [1:0]         ldSt_enable_output,
  output logic [RADDR_W-1:0] destReg_addr_output,
  output logic               we_output,
  output logic [1:0]         bp_output
);

  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] COP_ADD  = 4'b0000;
  localparam logic [3:0] COP_SUB  = 4'b0001;
  localparam logic [3:0] COP_AND  = 4'b0010;
  localparam logic [3:0] COP_MOVI = 4'b0011;
  localparam logic [3:0] COP_OR   = 4'b0100;
  localparam logic [3:0] COP_XOR  = 4'b0101;
  localparam logic [3:0] COP_LD   = 4'b0110;
  localparam logic [3:0] COP_ST   = 4'b0111;
  localparam logic [3:0] COP_MUL  = 4'b1000;
  localparam logic [3:0] COP_AI_E = 4'b1110;
  localparam logic [3:0] COP_AI_F = 4'b1111;

  // Reject parameter sets the datapath cannot handle.
  if ((DATA_W % MUL_BPC) != 0 || IMM_W >= DATA_W) begin : g_bad_params
    $error("alu_stage_mc: MUL_BPC must divide DATA_W and IMM_W must be < DATA_W");
  end

  logic               load;
  logic               valid_reg;
  logic [DATA_W-1:0]  a_reg;
  logic [DATA_W-1:0]  b_reg;
  logic [3:0]         cop_reg;
  logic [IMM_W-1:0]   imm_reg;
  logic               word_access_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [1:0]         ldst_reg;
  logic [RADDR_W-1:0] dest_reg;
  logic               we_reg;
  logic [1:0]         bp_reg;

  logic [DATA_W-1:0]  b_op;
  logic [DATA_W-1:0]  sum;
  logic [DATA_W-1:0]  diff;
  logic [DATA_W-1:0]  mul_result;
  logic               mul_ovf;
  logic               mul_run;

  // The stage only advances when the hazard unit allows and no multiply is running.
  assign load = enable_alu && !busy;

  // Pipeline register: capture the decoded instruction or hold it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg       <= 1'b0;
      a_reg           <= '0;
      b_reg           <= '0;
      cop_reg         <= '0;
      imm_reg         <= '0;
      word_access_reg <= 1'b0;
      data_reg        <= '0;
      ldst_reg        <= '0;
      dest_reg        <= '0;
      we_reg          <= 1'b0;
      bp_reg          <= '0;
    end else if (load) begin
      valid_reg       <= in_valid;
      a_reg           <= regA;
      b_reg           <= regB;
      cop_reg         <= cop;
      imm_reg         <= inmediate;
      word_access_reg <= word_access_from_decode;
      data_reg        <= dataReg;
      ldst_reg        <= ldSt_enable;
      dest_reg        <= destReg_addr;
      we_reg          <= we;
      bp_reg          <= bp_input;
    end
  end

  // Operand B: zero-extended immediate for immediate-form ops, register otherwise.
  always_comb begin
    case (cop_reg)
      COP_MOVI, COP_LD, COP_ST, COP_AI_E, COP_AI_F:
        b_op = {{(DATA_W-IMM_W){1'b0}}, imm_reg};
      default:
        b_op = b_reg;
    endcase
  end

  assign sum  = a_reg + b_op;
  assign diff = a_reg - b_op;

  // Result and overflow select; carry-out is dropped, OVF is signed overflow.
  always_comb begin
    alu_result = '0;
    OVF        = 1'b0;
    case (cop_reg)
      COP_ADD, COP_LD, COP_ST, COP_AI_E, COP_AI_F: begin
        alu_result = sum;
        OVF        = (a_reg[MSB] == b_op[MSB]) && (sum[MSB] != a_reg[MSB]);
      end
      COP_SUB: begin
        alu_result = diff;
        OVF        = (a_reg[MSB] != b_op[MSB]) && (diff[MSB] != a_reg[MSB]);
      end
      COP_AND:  alu_result = a_reg & b_op;
      COP_OR:   alu_result = a_reg | b_op;
      COP_XOR:  alu_result = a_reg ^ b_op;
      COP_MOVI: alu_result = b_op;
      COP_MUL: begin
        alu_result = mul_result;
        OVF        = mul_ovf;
      end
      default: begin
        alu_result = '0;
        OVF        = 1'b0;
      end
    endcase
  end

`ifdef ALU_STAGE_MUL_EN
  localparam int MUL_STEPS = DATA_W / MUL_BPC;
  localparam int CNT_W     = $clog2(MUL_STEPS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } mul_state_t;

  mul_state_t          state_reg;
  mul_state_t          state_next;
  logic                mul_start;
  logic [2*DATA_W-1:0] acc_reg;
  logic [2*DATA_W-1:0] mcand_reg;
  logic [DATA_W-1:0]   mplier_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*DATA_W-1:0] mul_partial;

  // Start on the same edge that captures a valid MUL, so operands come from the inputs.
  assign mul_start   = load && in_valid && (cop == COP_MUL);
  assign mul_partial = mcand_reg * {{(2*DATA_W-MUL_BPC){1'b0}}, mplier_reg[MUL_BPC-1:0]};

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next state: DONE behaves like IDLE so a following MUL can start with no bubble.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: state_next = mul_start ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_reg == CNT_W'(1)) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shift-and-add datapath: multiplicand shifts left, multiplier shifts right.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else if (mul_start) begin
      acc_reg    <= '0;
      mcand_reg  <= {{DATA_W{1'b0}}, regA};
      mplier_reg <= regB;
      cnt_reg    <= CNT_W'(MUL_STEPS);
    end else if (state_reg == ST_RUN) begin
      acc_reg    <= acc_reg + mul_partial;
      mcand_reg  <= mcand_reg << MUL_BPC;
      mplier_reg <= mplier_reg >> MUL_BPC;
      cnt_reg    <= cnt_reg - CNT_W'(1);
    end
  end

  assign mul_result = acc_reg[DATA_W-1:0];
  assign mul_ovf    = |acc_reg[2*DATA_W-1:DATA_W];
  assign mul_run    = (state_reg == ST_RUN);
`else
  assign busy       = 1'b0;
  assign mul_result = '0;
  assign mul_ovf    = 1'b0;
  assign mul_run    = 1'b0;
`endif

  // Forwarded fields; side-effecting controls are squashed for bubbles and while multiplying.
  assign out_valid           = valid_reg && !mul_run;
  assign we_output           = we_reg && out_valid;
  assign ldSt_enable_output  = out_valid ? ldst_reg : 2'b00;
  assign word_access         = word_access_reg;
  assign dataReg_output      = data_reg;
  assign destReg_addr_output = dest_reg;
  assign bp_output           = bp_reg;

endmodule

// File: tb/tb_alu_stage_mc.sv
// Self-checking bench for alu_stage_mc: directed cases plus randomized
// instructions compared against an arithmetic reference model.
module tb_alu_stage_mc;

  localparam int DW      = 16;
  localparam int IW      = 9;
  localparam int AW      = 3;
  localparam int MUL_CYC = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable_alu;
  logic          in_valid;
  logic [DW-1:0] regA;
  logic [DW-1:0] regB;
  logic [3:0]    cop;
  logic [IW-1:0] inmediate;
  logic          word_access_from_decode;
  logic [DW-1:0] dataReg;
  logic [1:0]    ldSt_enable;
  logic [AW-1:0] destReg_addr;
  logic          we;
  logic [1:0]    bp_input;
  logic [DW-1:0] alu_result;
  logic          OVF;
  logic          out_valid;
  logic          busy;
  logic          word_access;
  logic [DW-1:0] dataReg_output;
  logic [1:0]    ldSt_enable_output;
  logic [AW-1:0] destReg_addr_output;
  logic          we_output;
  logic [1:0]    bp_output;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  alu_stage_mc #(.DATA_W(DW), .IMM_W(IW), .RADDR_W(AW), .MUL_BPC(1)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable_alu              (enable_alu),
    .in_valid                (in_valid),
    .regA                    (regA),
    .regB                    (regB),
    .cop                     (cop),
    .inmediate               (inmediate),
    .word_access_from_decode (word_access_from_decode),
    .dataReg                 (dataReg),
    .ldSt_enable             (ldSt_enable),
    .destReg_addr            (destReg_addr),
    .we                      (we),
    .bp_input                (bp_input),
    .alu_result              (alu_result),
    .OVF                     (OVF),
    .out_valid               (out_valid),
    .busy                    (busy),
    .word_access             (word_access),
    .dataReg_output          (dataReg_output),
    .ldSt_enable_output      (ldSt_enable_output),
    .destReg_addr_output     (destReg_addr_output),
    .we_output               (we_output),
    .bp_output               (bp_output)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: returns {ovf, result} from plain integer arithmetic.
  function automatic logic [DW:0] model(input logic [3:0] c, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic [IW-1:0] imm);
    logic [DW-1:0]   bop;
    int              r;
    longint unsigned p;
    logic [DW-1:0]   res;
    logic            ovf;
    bop = (c inside {4'd3, 4'd6, 4'd7, 4'd14, 4'd15}) ? DW'(imm) : b;
    res = '0;
    ovf = 1'b0;
    case (c)
      4'd0, 4'd6, 4'd7, 4'd14, 4'd15: begin
        r   = int'($signed(a)) + int'($signed(bop));
        res = r[DW-1:0];
        ovf = (r > 32767) || (r < -32768);
      end
      4'd1: begin
        r   = int'($signed(a)) - int'($signed(bop));
        res = r[DW-1:0];
        ovf = (r > 32767) || (r < -32768);
      end
      4'd2: res = a & bop;
      4'd4: res = a | bop;
      4'd5: res = a ^ bop;
      4'd3: res = bop;
      4'd8: begin
`ifdef ALU_STAGE_MUL_EN
        p   = longint'(a) * longint'(bop);
        res = p[DW-1:0];
        ovf = (p >> DW) != 0;
`else
        p   = 0;
        res = '0;
        ovf = 1'b0;
`endif
      end
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
    return {ovf, res};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, alu_result, 0);
    check({tag, "_ovf"}, OVF, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_word_access"}, word_access, 0);
    check({tag, "_dataReg"}, dataReg_output, 0);
    check({tag, "_ldst"}, ldSt_enable_output, 0);
    check({tag, "_dest"}, destReg_addr_output, 0);
    check({tag, "_we"}, we_output, 0);
    check({tag, "_bp"}, bp_output, 0);
  endtask

  // One instruction: offer it, follow a multiply to DONE if one starts, then check.
  task automatic txn(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [IW-1:0] imm, input logic v, input logic w,
                     input logic [1:0] ls, input logic [DW-1:0] dr, input logic [AW-1:0] dst,
                     input logic wa, input logic [1:0] bp, input bit hold);
    logic [DW:0] exp;
    bit          mul_runs;
    int          cycles;
    exp = model(c, a, b, imm);
`ifdef ALU_STAGE_MUL_EN
    mul_runs = v && (c == 4'd8);
`else
    mul_runs = 1'b0;
`endif
    @(negedge clk);
    enable_alu = 1'b1; in_valid = v; cop = c; regA = a; regB = b; inmediate = imm;
    we = w; ldSt_enable = ls; dataReg = dr; destReg_addr = dst;
    word_access_from_decode = wa; bp_input = bp;
    @(posedge clk); #1;
    if (mul_runs) begin
      check("mul_busy_start", busy, 1);
      cycles = 0;
      while (busy === 1'b1 && cycles < 64) begin
        check("run_out_valid", out_valid, 0);
        check("run_we", we_output, 0);
        check("run_ldst", ldSt_enable_output, 0);
        cycles++;
        @(negedge clk);
        enable_alu = 1'($urandom_range(0, 1));
        regA = DW'($urandom); regB = DW'($urandom); cop = 4'($urandom);
        in_valid = 1'($urandom); we = 1'($urandom); dataReg = DW'($urandom);
        @(posedge clk); #1;
      end
      check("mul_busy_cycles", cycles, MUL_CYC);
    end else begin
      check("busy_low", busy, 0);
    end
    check("out_valid", out_valid, v);
    check("we_output", we_output, w & v);
    check("ldst_output", ldSt_enable_output, v ? ls : 2'b00);
    if (v) begin
      check("result", alu_result, exp[DW-1:0]);
      check("ovf", OVF, exp[DW]);
    end
    check("word_access", word_access, wa);
    check("dataReg_output", dataReg_output, dr);
    check("dest_output", destReg_addr_output, dst);
    check("bp_output", bp_output, bp);
    $display("txn %0d: cop=%h a=%h b=%h imm=%h valid=%0d -> result=%h ovf=%0d expected=%h/%0d",
             n_txn, c, a, b, imm, v, alu_result, OVF, exp[DW-1:0], exp[DW]);
    n_txn++;
    if (hold) begin
      @(negedge clk);
      enable_alu = 1'b0;
      regA = DW'($urandom); cop = 4'($urandom);
      @(posedge clk); #1;
      check("hold_busy", busy, 0);
      if (!mul_runs) begin
        check("hold_out_valid", out_valid, v);
        if (v) check("hold_result", alu_result, exp[DW-1:0]);
      end
    end
  endtask

  // Watchdog against a hung simulation.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; enable_alu = 1'b0; in_valid = 1'b0; regA = '0; regB = '0; cop = '0;
    inmediate = '0; word_access_from_decode = 1'b0; dataReg = '0; ldSt_enable = '0;
    destReg_addr = '0; we = 1'b0; bp_input = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_init");
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a multiply, then a plain ADD.
    @(negedge clk);
    enable_alu = 1'b1; in_valid = 1'b1; cop = 4'd8; regA = 16'h1234; regB = 16'h0056;
    we = 1'b1; ldSt_enable = 2'b11; dataReg = 16'hCAFE; destReg_addr = 3'd5;
    word_access_from_decode = 1'b1; bp_input = 2'b10;
    @(posedge clk);
    @(negedge clk);
    enable_alu = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_mul");
    @(negedge clk);
    reset = 1'b1;
    txn(4'd0, 16'h0003, 16'h0004, 9'h000, 1, 1, 2'b00, 16'h1111, 3'd1, 0, 2'b00, 0);

    // Directed arithmetic cases.
    txn(4'd0, 16'h7FFF, 16'h0001, 9'h000, 1, 1, 2'b00, 16'h2222, 3'd2, 0, 2'b01, 0);
    txn(4'd1, 16'h0005, 16'h0003, 9'h000, 1, 1, 2'b00, 16'h3333, 3'd3, 1, 2'b00, 1);
    txn(4'd3, 16'h5555, 16'hAAAA, 9'h1FF, 1, 1, 2'b00, 16'h4444, 3'd4, 0, 2'b00, 0);
    txn(4'd7, 16'h0100, 16'hFFFF, 9'h004, 1, 0, 2'b10, 16'hBEEF, 3'd0, 1, 2'b11, 0);
    txn(4'd8, 16'h0012, 16'h0034, 9'h000, 1, 1, 2'b00, 16'h5555, 3'd6, 0, 2'b00, 0);
    txn(4'd8, 16'h0100, 16'h0100, 9'h000, 1, 1, 2'b00, 16'h6666, 3'd7, 1, 2'b01, 0);

    // Bubble with write enable set.
    txn(4'd0, 16'h0001, 16'h0002, 9'h000, 0, 1, 2'b11, 16'h7777, 3'd1, 0, 2'b00, 0);

    // Back-to-back multiplies, second one held in DONE.
    txn(4'd8, 16'hFFFF, 16'hFFFF, 9'h000, 1, 1, 2'b01, 16'h8888, 3'd2, 1, 2'b10, 0);
    txn(4'd8, 16'h00FF, 16'h0101, 9'h000, 1, 1, 2'b00, 16'h9999, 3'd3, 0, 2'b01, 1);
    txn(4'd8, 16'h0002, 16'h0003, 9'h000, 0, 1, 2'b10, 16'hAAAA, 3'd4, 1, 2'b00, 0);

    // Randomized instructions.
    for (int i = 0; i < 80; i++) begin
      txn(4'($urandom_range(0, 15)), DW'($urandom), DW'($urandom), IW'($urandom),
          1'($urandom_range(0, 4) != 0), 1'($urandom), 2'($urandom), DW'($urandom),
          AW'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_stage_mc.md
# alu_stage_mc

Parametrised execute stage: captures decoded operands into a pipeline register, selects register or zero-extended immediate as operand B, and computes a single-cycle ALU result or an iterative multi-cycle unsigned multiply. Sits between decode and memory stage. Asserts `busy` to freeze decode while a multiply is in flight, and forwards store data, load/store enables, write-back address and branch bits alongside the result.

## Interface
- `DATA_W`, 16: operand/result width
- `IMM_W`, 9: immediate width, must be < `DATA_W`
- `RADDR_W`, 3: destination register address width
- `MUL_BPC`, 1: multiplier bits consumed per cycle; must divide `DATA_W`

- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `enable_alu` in 1: advance enable from hazard unit
- `in_valid` in 1: decode presents a real instruction (0 = bubble)
- `regA`, `regB` in `DATA_W`: operands
- `cop` in 4: operation code
- `inmediate` in `IMM_W`: immediate
- `word_access_from_decode` in 1, `dataReg` in `DATA_W`, `ldSt_enable` in 2, `destReg_addr` in `RADDR_W`, `we` in 1, `bp_input` in 2: forwarded fields
- `alu_result` out `DATA_W`: result
- `OVF` out 1: overflow flag
- `out_valid` out 1: result/forwarded fields valid this cycle
- `busy` out 1: multiply in progress; decode must hold
- `word_access`, `dataReg_output`, `ldSt_enable_output`, `destReg_addr_output`, `we_output`, `bp_output`: registered forwarded fields

## Operation
- Pipeline register loads all inputs when `enable_alu && !busy`; otherwise it holds.
- Operand B is `{0, inmediate}` for cop 0011, 0110, 0111, 1110, 1111; otherwise `regB`.
- Ops:
  - 0000 ADD
  - 0001 SUB (A−B)
  - 0010 AND
  - 0100 OR
  - 0101 XOR
  - 0011 MOVI (result = B)
  - 0110 LD, 0111 ST, 1110, 1111: A+B address/add-immediate
  - 1000 MUL: low `DATA_W` bits of unsigned A×B
  - Others: result 0, `OVF` 0
- `OVF` for add-type and SUB: signed two's-complement overflow, with carry-out discarded. For logic and MOVI, `OVF` is 0. For MUL, `OVF` is 1 when the upper `DATA_W` product bits are non-zero.
- If a bubble is captured (`in_valid` = 0), `out_valid` and `we_output` are 0 and `ldSt_enable_output` is 00. Other fields are don't-care.
- MUL FSM:
  - IDLE: a captured valid MUL enters RUN and asserts `busy`. The accumulator clears and the counter loads `DATA_W/MUL_BPC`.
  - RUN: each cycle adds A×(next `MUL_BPC` bits of B, LSB first), shifted, into a 2·`DATA_W` accumulator, then decrements the counter.
  - At counter = 1, the next state is DONE.
  - DONE: one cycle. `busy` is 0, `out_valid` is 1, the result is presented, and the state returns to IDLE.
- During RUN, `out_valid` and `we_output` read 0, and `ldSt_enable_output` reads 00.
- `enable_alu` is ignored while `busy` is high. A low `enable_alu` in DONE still completes DONE.
- Reset (any time, including mid-multiply) clears state to IDLE, `busy` 0, and all outputs to 0.

## Timing
- Non-MUL: result and flags are combinational from the register, valid the cycle after capture (latency 1).
- MUL: latency `DATA_W/MUL_BPC` + 1 cycles from capture to DONE. `busy` is high for `DATA_W/MUL_BPC` cycles.
- An instruction offered while `busy` is held by decode and captured on the first edge where `busy` is 0 and `enable_alu` is 1. This includes the edge ending DONE, so back-to-back MULs incur no extra bubble.

## Configuration
- `ALU_STAGE_MUL_EN` defined: multiplier datapath and FSM are compiled in as above.
- Not defined: no accumulator or FSM. `busy` is tied 0. Cop 1000 yields result 0, `OVF` 0 in one cycle, and `out_valid` follows `in_valid`.

## Test plan
- Reset low mid-MUL, then high: all outputs 0, `busy` 0, and the next ADD 3+4 gives 7 one cycle after capture.
- ADD 0x7FFF+0x0001: result 0x8000, `OVF` 1. SUB 0x0005−0x0003: result 0x0002, `OVF` 0.
- MOVI with `inmediate` 0x1FF and regB 0xAAAA: result 0x01FF. ST with A 0x0100 and imm 0x004: result 0x0104, `dataReg_output` forwarded.
- MUL 0x0012×0x0034 (`MUL_BPC` 1): `busy` high 16 cycles, then DONE with 0x03A8, `OVF` 0. MUL 0x0100×0x0100: result 0x0000, `OVF` 1.
- Bubble capture (`in_valid` 0, `we` 1): `out_valid` 0, `we_output` 0.
- Back-to-back MULs, with `enable_alu` toggling during RUN: second MUL captured at the DONE edge, both results correct. Repeat with the macro undefined: MUL gives 0 in one cycle and `busy` never asserts.
